// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: hex font and dark pattern.
package seg7_pkg;

  // All segments off (outputs are active-low).
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  // Hex font, segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG7_FONT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display data/control bundle between the host (master) and the scan controller (slave).
interface seg7_scan_ctrl_if #(
  parameter int unsigned NDIG = 8
);
  logic [4*NDIG-1:0] x;
  logic [NDIG-1:0]   dp_in;
  logic [NDIG-1:0]   blank;
  logic              lz_en;
  logic [3:0]        bright;
  logic              load;
  logic [6:0]        seg;
  logic              dp;
  logic [NDIG-1:0]   an;
  logic              frame_done;

  modport master (
    output x, dp_in, blank, lz_en, bright, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  x, dp_in, blank, lz_en, bright, load,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_font.sv
// Combinational nibble-to-segment decode using the shared hex font.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_FONT[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot timer, digit index, tear-free
// double buffer, leading-zero suppression, PWM dimming, registered outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG  = 8,
  parameter int unsigned DIV_W = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned      IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  idx_q;

  logic [4*NDIG-1:0] x_pend_q, x_act_q;
  logic [NDIG-1:0]   dp_pend_q, dp_act_q;
  logic [NDIG-1:0]   bl_pend_q, bl_act_q;
  logic              pend_vld_q;

  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              fd_q, fd_d;

  logic              slot_wrap;
  logic              frame_wrap;
  logic [NDIG-1:0]   keep;
  logic [3:0]        nib [NDIG];
  logic [3:0]        nib_cur;
  logic [6:0]        font_seg;
  logic              supp;
  logic              gate;
  logic              dark;

  assign slot_wrap  = (div_q == '1);
  assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);

  // Free-running slot timer and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
      if (slot_wrap) begin
        idx_q <= frame_wrap ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Double buffer: loads land in pending, pending moves to active only at frame wrap.
  // A load coinciding with the wrap still lands in pending after the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pend_q   <= '0;
      dp_pend_q  <= '0;
      bl_pend_q  <= '0;
      x_act_q    <= '0;
      dp_act_q   <= '0;
      bl_act_q   <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (frame_wrap && pend_vld_q) begin
        x_act_q    <= x_pend_q;
        dp_act_q   <= dp_pend_q;
        bl_act_q   <= bl_pend_q;
        pend_vld_q <= 1'b0;
      end
      if (bus.load) begin
        x_pend_q   <= bus.x;
        dp_pend_q  <= bus.dp_in;
        bl_pend_q  <= bus.blank;
        pend_vld_q <= 1'b1;
      end
    end
  end

  // keep[g] is set when some active nibble at position g or above is non-zero;
  // digit 0 is always kept.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    assign nib[g]  = x_act_q[4*g +: 4];
    assign keep[g] = (g == 0) ? 1'b1 : |x_act_q[4*NDIG-1:4*g];
  end

  assign nib_cur = nib[idx_q];

  seg7_font u_font (
    .nib_i (nib_cur),
    .seg_o (font_seg)
  );

  assign supp = bus.lz_en && !keep[idx_q];
  assign gate = (div_q[DIV_W-1 -: 4] <= bus.bright);
  assign dark = bl_act_q[idx_q] || supp || !gate;

  // Next pin state for the current digit slot
  always_comb begin
    an_d  = '1;
    seg_d = SEG7_BLANK;
    dp_d  = 1'b1;
    fd_d  = frame_wrap;
    if (!dark) begin
      an_d[idx_q] = 1'b0;
      seg_d       = font_seg;
      dp_d        = ~dp_act_q[idx_q];
    end
  end

  // Output registers, dark while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= SEG7_BLANK;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG = 4, DIV_W = 4 (16-cycle slots, 64-cycle frames).
module tb_seg7_scan_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NDIG(4)) bus ();

  seg7_scan_ctrl #(.NDIG(4), .DIV_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Hand-written expected segment patterns, {g,f,e,d,c,b,a} active-low
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
                         SF = 7'b0001110, SX = 7'b1111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] bl, input logic [3:0] dpv,
                                     input logic [15:0] xv);
    return {bl, dpv, xv};
  endfunction

  task automatic drive(input logic [23:0] v);
    bus.x     = v[15:0];
    bus.dp_in = v[19:16];
    bus.blank = v[23:20];
    bus.load  = 1'b1;
  endtask

  // Checks one full frame of pins (sample k shows slot (k-1)/16, cycle (k-1)%16),
  // optionally strobing load right after samples ka and kb.
  task automatic run_frame(input string tag, input logic [27:0] es, input logic [3:0] edp,
                           input logic [3:0] edark, input logic [3:0] br,
                           input int ka, input logic [23:0] la,
                           input int kb, input logic [23:0] lb);
    for (int k = 1; k <= 64; k++) begin
      int         s;
      int         c;
      logic       lit;
      logic [3:0] ean;
      logic [6:0] eseg;
      logic       edpo;
      @(negedge clk);
      s    = (k - 1) / 16;
      c    = (k - 1) % 16;
      lit  = !edark[s] && (c <= int'(br));
      ean  = 4'hF;
      if (lit) ean[s] = 1'b0;
      eseg = lit ? es[s*7 +: 7] : SX;
      edpo = !(lit && edp[s]);
      check($sformatf("%s.an@%0d", tag, k),  32'(bus.an),         32'(ean));
      check($sformatf("%s.seg@%0d", tag, k), 32'(bus.seg),        32'(eseg));
      check($sformatf("%s.dp@%0d", tag, k),  32'(bus.dp),         32'(edpo));
      check($sformatf("%s.fd@%0d", tag, k),  32'(bus.frame_done), 32'(k == 64));
      if (k == ka)      drive(la);
      else if (k == kb) drive(lb);
      else              bus.load = 1'b0;
    end
  endtask

  initial begin
    bus.x      = '0;
    bus.dp_in  = '0;
    bus.blank  = '0;
    bus.lz_en  = 1'b0;
    bus.bright = 4'd15;
    bus.load   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst.an",  32'(bus.an),         32'hF);
    check("rst.seg", 32'(bus.seg),        32'(SX));
    check("rst.dp",  32'(bus.dp),         32'h1);
    check("rst.fd",  32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;

    // Active data is zero until the first wrap; 12AF loaded early in the frame
    run_frame("F0", {S0, S0, S0, S0}, 4'b0000, 4'b0000, 4'd15, 1, mk(4'h0, 4'h0, 16'h12AF), 0, '0);
    // 12AF shown without tearing while 0000 then 0005 are loaded
    run_frame("F1", {S1, S2, SA, SF}, 4'b0000, 4'b0000, 4'd15,
              10, mk(4'h0, 4'h0, 16'h0000), 30, mk(4'h0, 4'b1001, 16'h0005));
    run_frame("F2", {S0, S0, S0, S5}, 4'b1001, 4'b0000, 4'd15, 0, '0, 0, '0);
    bus.lz_en = 1'b1;
    run_frame("F3_lz", {S0, S0, S0, S5}, 4'b1001, 4'b1110, 4'd15,
              20, mk(4'h0, 4'h0, 16'h3456), 0, '0);
    bus.lz_en = 1'b0;
    // 789A pending, then BCDE loaded in the wrap cycle
    run_frame("F4", {S3, S4, S5, S6}, 4'b0000, 4'b0000, 4'd15,
              20, mk(4'h0, 4'h0, 16'h789A), 63, mk(4'h0, 4'h0, 16'hBCDE));
    run_frame("F5", {S7, S8, S9, SA}, 4'b0000, 4'b0000, 4'd15, 0, '0, 0, '0);
    run_frame("F6", {SB, SC, SD, SE}, 4'b0000, 4'b0000, 4'd15,
              40, mk(4'b0100, 4'b0101, 16'h0123), 0, '0);
    run_frame("F7_blank", {S0, SX, S2, S3}, 4'b0101, 4'b0100, 4'd15, 0, '0, 0, '0);
    bus.bright = 4'd3;
    run_frame("F8_br3", {S0, SX, S2, S3}, 4'b0101, 4'b0100, 4'd3, 0, '0, 0, '0);
    bus.bright = 4'd0;
    run_frame("F9_br0", {S0, SX, S2, S3}, 4'b0101, 4'b0100, 4'd0, 0, '0, 0, '0);
    bus.bright = 4'd15;

    // Mid-slot reset with a pending load that must be discarded
    repeat (20) @(negedge clk);
    check("pre_rst.an",  32'(bus.an),  32'b1101);
    check("pre_rst.seg", 32'(bus.seg), 32'(S2));
    drive(mk(4'h0, 4'hF, 16'hFFFF));
    @(negedge clk);
    bus.load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.an",  32'(bus.an),         32'hF);
    check("async_rst.seg", 32'(bus.seg),        32'(SX));
    check("async_rst.dp",  32'(bus.dp),         32'h1);
    check("async_rst.fd",  32'(bus.frame_done), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frame("F10_rst", {S0, S0, S0, S0}, 4'b0000, 4'b0000, 4'd15, 0, '0, 0, '0);
    run_frame("F11_rst", {S0, S0, S0, S0}, 4'b0000, 4'b0000, 4'd15, 0, '0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
